// File: rtl/blinker_mem_arbiter.sv
// Two-master arbiter for a single-port 4096x32 RAM: m0 has priority, m1 is guaranteed a slot after MAX_HOLD m0 wins.
// One transfer per cycle; read data is returned 1 cycle after acceptance, steered to the owner.
module blinker_mem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int BE_W     = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  logic       req0, req1;
  logic       grant0, grant1;
  logic [3:0] hold_cnt;
  logic       rd_vld;
  logic       rd_own;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // m0 wins unless m1 is also waiting and m0 has used up its run of consecutive grants
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      if (req0 && !(req1 && hold_cnt == HOLD_MAX))
        grant0 = 1'b1;
      else if (req1)
        grant1 = 1'b1;
    end
  end

  assign m0_waitrequest = ~grant0;
  assign m1_waitrequest = ~grant1;

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    if (grant0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_write      = m0_write;
      mem_writedata  = m0_writedata;
    end else if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_write      = m1_write;
      mem_writedata  = m1_writedata;
    end
  end

  assign mem_chipselect = grant0 | grant1;
  assign mem_clken      = reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_vld   <= 1'b0;
      rd_own   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      // read+write on one master is a write, so no data is returned for it
      rd_vld <= (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);
      rd_own <= grant1;
      if (grant0 && req1)
        hold_cnt <= (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 4'd1;
      else
        hold_cnt <= '0;
    end
  end

  // gating with reset_n drops data for a read accepted just before reset
  assign m0_readdatavalid = rd_vld & ~rd_own & reset_n;
  assign m1_readdatavalid = rd_vld &  rd_own & reset_n;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

endmodule

// File: tb/tb_blinker_mem_arbiter.sv
// Bench for blinker_mem_arbiter: directed scenarios then randomized traffic against a reference model.
module tb_blinker_mem_arbiter;

  localparam int MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;

  blinker_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .BE_W(4), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // on-chip RAM: registered read, byte-lane writes
  logic [31:0] ram [0:4095];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      mem_readdata <= ram[mem_address];
    end
  end

  // reference model state
  logic [31:0] ref_mem [0:4095];
  int          wins = 0;
  logic        exp_vld = 1'b0;
  logic        exp_own = 1'b0;
  logic [31:0] exp_dat = '0;
  int          last_g = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // one clock cycle: check outputs mid-cycle against the model, then advance the model
  task automatic step();
    int g;
    logic r0, r1, v0, v1;
    @(negedge clk);
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    g = 0;
    if (reset_n) begin
      if (r0 && !(r1 && wins == MAX_HOLD)) g = 1;
      else if (r1) g = 2;
    end
    chk("wait0", m0_waitrequest, g != 1);
    chk("wait1", m1_waitrequest, g != 2);
    chk("chipselect", mem_chipselect, g != 0);
    chk("mem_addr", mem_address, g == 1 ? m0_address : g == 2 ? m1_address : 12'h0);
    chk("mem_be", mem_byteenable, g == 1 ? m0_byteenable : g == 2 ? m1_byteenable : 4'h0);
    chk("mem_wr", mem_write, g == 1 ? m0_write : g == 2 ? m1_write : 1'b0);
    chk("mem_wdata", mem_writedata, g == 1 ? m0_writedata : g == 2 ? m1_writedata : 32'h0);
    chk("clken", mem_clken, reset_n);
    v0 = reset_n && exp_vld && !exp_own;
    v1 = reset_n && exp_vld && exp_own;
    chk("rdv0", m0_readdatavalid, v0);
    chk("rdv1", m1_readdatavalid, v1);
    chk("rdata0", m0_readdata, v0 ? exp_dat : 32'h0);
    chk("rdata1", m1_readdata, v1 ? exp_dat : 32'h0);
    exp_vld = 1'b0;
    if (g == 1) begin
      if (m0_write) ref_mem[m0_address] = merge(ref_mem[m0_address], m0_writedata, m0_byteenable);
      else begin exp_vld = 1'b1; exp_own = 1'b0; exp_dat = ref_mem[m0_address]; end
    end else if (g == 2) begin
      if (m1_write) ref_mem[m1_address] = merge(ref_mem[m1_address], m1_writedata, m1_byteenable);
      else begin exp_vld = 1'b1; exp_own = 1'b1; exp_dat = ref_mem[m1_address]; end
    end
    if (g == 1 && r1) wins = (wins < MAX_HOLD) ? wins + 1 : wins;
    else wins = 0;
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic rd, input logic wr, input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic set_m1(input logic rd, input logic wr, input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic rand_req(input int n);
    int op;
    logic rd, wr;
    op = int'($urandom_range(0, 3));
    rd = (op != 1);
    wr = (op == 1 || op == 2);
    if (n == 0) set_m0(rd, wr, 12'($urandom_range(0, 15)), 4'($urandom), $urandom);
    else        set_m1(rd, wr, 12'($urandom_range(0, 15)), 4'($urandom), $urandom);
  endtask

  initial begin
    int m1_wait, max_wait;
    for (int i = 0; i < 4096; i++) begin ram[i] = '0; ref_mem[i] = '0; end

    // reset held with m0 requesting
    set_m0(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) step();
    reset_n = 1'b1;
    set_m0(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    step();

    // full write then read-back, then partial byte-lane write
    set_m0(1'b0, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF); step();
    set_m0(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);        step();
    chk("t2_rdv", m0_readdatavalid, 1'b1);
    chk("t2_rdata", m0_readdata, 32'hDEADBEEF);
    set_m0(1'b0, 1'b1, 12'h010, 4'b0001, 32'h000000AA); step();
    set_m0(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);           step();
    chk("t3_rdata", m0_readdata, 32'hDEADBEAA);

    // both masters reading continuously: four m0 grants then one m1
    set_m0(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
    set_m1(1'b1, 1'b0, 12'h011, 4'hF, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_grant", 32'(last_g), (i % 5 == 4) ? 32'd2 : 32'd1);
    end

    // alternating back-to-back reads
    set_m0(1'b0, 1'b1, 12'h001, 4'hF, 32'h11111111);
    set_m1(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);         step();
    set_m0(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    set_m1(1'b0, 1'b1, 12'h002, 4'hF, 32'h22222222); step();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        set_m0(1'b1, 1'b0, 12'h001, 4'hF, 32'h0); set_m1(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      end else begin
        set_m0(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);   set_m1(1'b1, 1'b0, 12'h002, 4'hF, 32'h0);
      end
      step();
      if (i % 2 == 0) chk("t5_data0", m0_readdata, 32'h11111111);
      else            chk("t5_data1", m1_readdata, 32'h22222222);
    end

    // reset right after an accepted m1 read, then reissue
    set_m0(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    set_m1(1'b1, 1'b0, 12'h002, 4'hF, 32'h0); step();
    set_m1(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    reset_n = 1'b0;                           step();
    chk("t6_rdv1_after", m1_readdatavalid, 1'b0);
    reset_n = 1'b1;                           step();
    set_m1(1'b1, 1'b0, 12'h002, 4'hF, 32'h0); step();
    chk("t6_reissue", m1_readdata, 32'h22222222);
    set_m1(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);   step();

    // randomized traffic; requests are held until granted
    m1_wait = 0;
    max_wait = 0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (!reset_n) m1_wait = 0;
      else if (m1_read | m1_write) begin
        if (last_g == 2) m1_wait = 0;
        else begin
          m1_wait++;
          if (m1_wait > max_wait) max_wait = m1_wait;
        end
      end
      if (last_g == 1 || !(m0_read | m0_write)) begin
        if ($urandom_range(0, 9) < 7) rand_req(0); else set_m0(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      end
      if (last_g == 2 || !(m1_read | m1_write)) begin
        if ($urandom_range(0, 9) < 7) rand_req(1); else set_m1(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      end
      reset_n = ($urandom_range(0, 99) != 0);
    end
    reset_n = 1'b1;
    step();
    chk("m1_max_wait_ok", 64'(max_wait <= MAX_HOLD), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
